// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper controller: coil phase table, FSM state
// encoding and the phase-index stepping rule.
package stepper_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // Entry i occupies bits [4*i +: 4]; index 0 is the least significant nibble.
    localparam logic [31:0] PHASE_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    function automatic logic [3:0] phase_of(input logic [2:0] idx);
        return PHASE_TABLE[{idx, 2'b00} +: 4];
    endfunction

    // Full-step always lands on an odd index so both neighbouring coils are driven.
    function automatic logic [2:0] next_index(input logic [2:0] idx,
                                              input logic       fwd,
                                              input logic       half);
        logic [2:0] n;
        if (half) begin
            n = fwd ? idx + 3'd1 : idx - 3'd1;
        end else begin
            n    = fwd ? idx + 3'd2 : idx - 3'd2;
            n[0] = 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Step-rate divider: while enabled, pulses tick once every 'period' cycles,
// counting from zero after a clear.
module step_timer #(
    parameter int PERIOD_W = 32
) (
    input  logic                sclk,
    input  logic                s_rst,
    input  logic                enable,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count;

    assign tick = enable && !clear && (count == period - PERIOD_W'(1));

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/stepper_ctrl.sv
// Stepper motor move controller: runs a fixed-length move at a fixed step
// period in half- or full-step mode and tracks signed position.
module stepper_ctrl
    import stepper_pkg::*;
#(
    parameter int PERIOD_W = 32,
    parameter int STEPS_W  = 16,
    parameter int POS_W    = 24
) (
    input  logic                    sclk,
    input  logic                    s_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    direct,
    input  logic                    half_step,
    input  logic                    hold_en,
    input  logic [PERIOD_W-1:0]     period,
    input  logic [STEPS_W-1:0]      steps,
    output logic [3:0]              stepdrive,
    output logic                    busy,
    output logic                    done,
    output logic [STEPS_W-1:0]      steps_left,
    output logic signed [POS_W-1:0] position
);

    // start is a single-cycle request honoured only in IDLE; abort is level-sampled
    // and only acts in RUN, where it overrides any step due on the same edge.

    state_t                    state;
    logic [2:0]                index;
    logic                      lat_dir;
    logic                      lat_half;
    logic [PERIOD_W-1:0]       lat_period;
    logic                      done_pend;

    logic                      tick;
    logic                      timer_clear;
    logic                      start_move;
    logic                      start_empty;
    logic                      abort_run;
    logic                      step_now;
    logic                      last_step;
    logic                      finish;
    logic [2:0]                index_next;
    logic [POS_W-1:0]          step_mag;
    logic signed [POS_W-1:0]   position_next;
    logic [3:0]                drive_next;
    logic [PERIOD_W-1:0]       period_clamped;

    assign busy = (state == ST_RUN);

    step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .sclk   (sclk),
        .s_rst  (s_rst),
        .enable (busy),
        .clear  (timer_clear),
        .period (lat_period),
        .tick   (tick)
    );

    always_comb begin
        start_move     = (state == ST_IDLE) && start && (steps != '0);
        start_empty    = (state == ST_IDLE) && start && (steps == '0);
        abort_run      = (state == ST_RUN) && abort;
        step_now       = (state == ST_RUN) && !abort && tick;
        last_step      = step_now && (steps_left == STEPS_W'(1));
        finish         = start_empty || abort_run || last_step;
        timer_clear    = (state == ST_IDLE) || abort_run;
        period_clamped = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;

        index_next     = next_index(index, lat_dir, lat_half);
        step_mag       = lat_half ? POS_W'(1) : POS_W'(2);
        position_next  = lat_dir ? position + step_mag : position - step_mag;

        drive_next = phase_of(index);
        if (step_now) begin
            drive_next = phase_of(index_next);
        end else if ((state == ST_IDLE) && !hold_en) begin
            drive_next = 4'b0000;
        end
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state      <= ST_IDLE;
            index      <= 3'd0;
            lat_dir    <= 1'b0;
            lat_half   <= 1'b0;
            lat_period <= PERIOD_W'(2);
            steps_left <= '0;
            position   <= '0;
            stepdrive  <= 4'b0000;
            done_pend  <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_move) begin
                        state      <= ST_RUN;
                        lat_dir    <= direct;
                        lat_half   <= half_step;
                        lat_period <= period_clamped;
                        steps_left <= steps;
                    end
                end
                ST_RUN: begin
                    if (abort_run) begin
                        state <= ST_IDLE;
                    end else if (step_now) begin
                        index      <= index_next;
                        position   <= position_next;
                        steps_left <= steps_left - STEPS_W'(1);
                        if (last_step) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            stepdrive <= drive_next;
            // done trails the end of a move by one cycle so it lands after IDLE is reached.
            done_pend <= finish;
            done      <= done_pend;
        end
    end

endmodule

// File: tb/tb_stepper_ctrl.sv
// Self-checking bench for stepper_ctrl: table of moves with a per-step
// scoreboard, plus hand sequences for abort, empty move, hold, wrap and reset.
module tb_stepper_ctrl;

    localparam int PW = 32;
    localparam int SW = 16;
    localparam int QW = 8;
    localparam int EW = 4 + QW + SW;

    logic          sclk;
    logic          s_rst;
    logic          start;
    logic          abort;
    logic          direct;
    logic          half_step;
    logic          hold_en;
    logic [PW-1:0] period;
    logic [SW-1:0] steps;
    logic [3:0]    stepdrive;
    logic          busy;
    logic          done;
    logic [SW-1:0] steps_left;
    logic [QW-1:0] position;

    int total;
    int bad;

    logic [EW-1:0] exp_q[$];
    int            exp_t_q[$];

    logic [3:0]    ph [8];
    int            m_idx;
    logic [QW-1:0] m_pos;

    typedef struct {
        logic          dir;
        logic          half;
        logic [PW-1:0] per;
        logic [SW-1:0] nsteps;
        logic [3:0]    exp_drive;
        logic [QW-1:0] exp_pos;
    } vec_t;

    vec_t vecs[6];
    vec_t v;

    stepper_ctrl #(
        .PERIOD_W (PW),
        .STEPS_W  (SW),
        .POS_W    (QW)
    ) dut (
        .sclk       (sclk),
        .s_rst      (s_rst),
        .start      (start),
        .abort      (abort),
        .direct     (direct),
        .half_step  (half_step),
        .hold_en    (hold_en),
        .period     (period),
        .steps      (steps),
        .stepdrive  (stepdrive),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left),
        .position   (position)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_next(input int idx, input logic fwd, input logic half);
        int n;
        if (half) begin
            n = fwd ? (idx + 1) % 8 : (idx + 7) % 8;
        end else begin
            n = fwd ? (idx + 2) % 8 : (idx + 6) % 8;
            n = n | 1;
        end
        return n;
    endfunction

    task automatic do_reset();
        @(negedge sclk);
        s_rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        s_rst = 1'b0;
        m_idx = 0;
        m_pos = '0;
    endtask

    task automatic run_move(input vec_t mv, input bit scramble);
        int            eff;
        int            k;
        int            limit;
        bit            got_done;
        logic [SW-1:0] last_sl;
        logic [EW-1:0] e;
        int            et;
        eff = (mv.per < 2) ? 2 : int'(mv.per);
        for (int j = 1; j <= int'(mv.nsteps); j++) begin
            m_idx = model_next(m_idx, mv.dir, mv.half);
            m_pos = mv.dir ? m_pos + (mv.half ? 8'd1 : 8'd2) : m_pos - (mv.half ? 8'd1 : 8'd2);
            exp_q.push_back({ph[m_idx], m_pos, SW'(int'(mv.nsteps) - j)});
            exp_t_q.push_back(eff * j);
        end
        limit = eff * int'(mv.nsteps);
        @(negedge sclk);
        direct = mv.dir; half_step = mv.half; period = mv.per; steps = mv.nsteps;
        start = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("steps_loaded", steps_left, mv.nsteps);
        last_sl = steps_left;
        k = 0;
        got_done = 1'b0;
        while (!got_done && k < limit + 20) begin
            if (scramble && k < limit - 1) begin
                direct    = 1'($urandom_range(0, 1));
                half_step = 1'($urandom_range(0, 1));
                period    = PW'($urandom_range(0, 9));
                steps     = SW'($urandom_range(0, 9));
                start     = 1'($urandom_range(0, 1));
            end else begin
                direct = mv.dir; half_step = mv.half; period = mv.per; steps = mv.nsteps;
                start = 1'b0;
            end
            @(posedge sclk); #1;
            k++;
            if (steps_left != last_sl) begin
                last_sl = steps_left;
                if (exp_q.size() == 0) begin
                    check("unexpected_step", 1'b1, 1'b0);
                end else begin
                    e  = exp_q.pop_front();
                    et = exp_t_q.pop_front();
                    check("step_drive", stepdrive, e[EW-1 -: 4]);
                    check("step_pos", position, e[SW +: QW]);
                    check("step_left", steps_left, e[SW-1:0]);
                    check("step_cycle", k, et);
                end
            end
            if (done) begin
                got_done = 1'b1;
                check("done_cycle", k, limit + 1);
            end
        end
        start = 1'b0;
        if (!got_done) check("done_timeout", 1'b0, 1'b1);
        check("steps_all_seen", exp_q.size(), 0);
        exp_q.delete();
        exp_t_q.delete();
        check("final_drive", stepdrive, mv.exp_drive);
        check("final_pos", position, mv.exp_pos);
        check("final_busy", busy, 1'b0);
        check("final_left", steps_left, 0);
        @(posedge sclk); #1;
        check("done_width", done, 1'b0);
    endtask

    initial begin
        bit saw_done;
        total = 0; bad = 0;
        ph[0] = 4'b0001; ph[1] = 4'b0011; ph[2] = 4'b0010; ph[3] = 4'b0110;
        ph[4] = 4'b0100; ph[5] = 4'b1100; ph[6] = 4'b1000; ph[7] = 4'b1001;

        vecs[0] = '{1'b1, 1'b1, 32'd4, 16'd3, 4'b0110, 8'h03};
        vecs[1] = '{1'b0, 1'b0, 32'd2, 16'd2, 4'b1001, 8'hFF};
        vecs[2] = '{1'b1, 1'b0, 32'd0, 16'd3, 4'b1100, 8'h05};
        vecs[3] = '{1'b0, 1'b1, 32'd1, 16'd4, 4'b0011, 8'h01};
        vecs[4] = '{1'b1, 1'b1, 32'd5, 16'd1, 4'b0010, 8'h02};
        vecs[5] = '{1'b0, 1'b0, 32'd3, 16'd5, 4'b0011, 8'hF8};

        s_rst = 1'b1; start = 1'b0; abort = 1'b0; direct = 1'b0; half_step = 1'b0;
        hold_en = 1'b1; period = '0; steps = '0;
        m_idx = 0; m_pos = '0;
        repeat (2) @(posedge sclk);
        #1;
        check("rst_drive", stepdrive, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_left", steps_left, 0);
        check("rst_pos", position, 0);
        @(negedge sclk);
        s_rst = 1'b0;
        @(posedge sclk); #1;
        check("idle_hold_drive", stepdrive, 4'b0001);

        for (int i = 0; i < 6; i++) begin
            run_move(vecs[i], (i % 2) == 1);
        end

        @(negedge sclk);
        hold_en = 1'b0;
        @(posedge sclk); #1;
        check("hold_off_drive", stepdrive, 4'b0000);
        @(negedge sclk);
        hold_en = 1'b1;
        @(posedge sclk); #1;
        check("hold_on_drive", stepdrive, 4'b0011);

        @(negedge sclk);
        steps = '0; period = 32'd4; direct = 1'b1; half_step = 1'b1; start = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0;
        check("empty_busy", busy, 1'b0);
        check("empty_done_early", done, 1'b0);
        @(posedge sclk); #1;
        check("empty_done", done, 1'b1);
        check("empty_drive", stepdrive, 4'b0011);
        check("empty_pos", position, 8'hF8);
        @(posedge sclk); #1;
        check("empty_done_width", done, 1'b0);

        @(negedge sclk);
        abort = 1'b1;
        @(posedge sclk); #1;
        abort = 1'b0;
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge sclk); #1;
            if (done) saw_done = 1'b1;
        end
        check("idle_abort_done", saw_done, 1'b0);
        check("idle_abort_pos", position, 8'hF8);

        do_reset();
        v = '{1'b0, 1'b0, 32'd2, 16'd2, 4'b1100, 8'hFC};
        run_move(v, 1'b0);

        do_reset();
        @(negedge sclk);
        direct = 1'b1; half_step = 1'b1; period = 32'd3; steps = 16'd5; start = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        check("abort_first_step", stepdrive, 4'b0011);
        repeat (2) @(posedge sclk);
        #1;
        abort = 1'b1;
        @(posedge sclk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_left", steps_left, 16'd4);
        check("abort_pos", position, 8'h01);
        check("abort_drive", stepdrive, 4'b0011);
        check("abort_done_early", done, 1'b0);
        @(posedge sclk); #1;
        check("abort_done", done, 1'b1);
        @(posedge sclk); #1;
        check("abort_done_width", done, 1'b0);

        do_reset();
        v = '{1'b1, 1'b1, 32'd2, 16'd128, 4'b0001, 8'h80};
        run_move(v, 1'b0);

        do_reset();
        @(negedge sclk);
        direct = 1'b1; half_step = 1'b1; period = 32'd3; steps = 16'd5; start = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0;
        repeat (4) @(posedge sclk);
        #1;
        check("pre_reset_busy", busy, 1'b1);
        s_rst = 1'b1;
        #1;
        check("midrst_drive", stepdrive, 4'b0000);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_left", steps_left, 0);
        check("midrst_pos", position, 0);
        @(negedge sclk);
        s_rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge sclk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
